// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end feeding decode.
//
// Owns the fetch PC and issues sequential word fetches to a synchronous
// instruction memory with a fixed one-cycle read latency. Each returned
// word is buffered together with its PC in a small FIFO. The FIFO head is
// offered to decode over a valid/ready handshake. A redirect from execute
// reloads the fetch PC and throws away everything buffered or in flight.
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_i         synchronous reset, active low
//   redirect_i    single-cycle pulse: load fetch PC from target_i and flush
//   target_i      redirect address (low two bits are ignored)
//   imem_req_o    fetch request this cycle
//   imem_addr_o   word-aligned fetch address
//   imem_rdata_i  instruction word, valid one cycle after its request
//   valid_o       FIFO head valid
//   ready_i       decode accepts the head
//   instr_o       head instruction
//   pc_o          head PC
//   pc_plus4_o    head PC + 4 (wraps modulo 2^32)
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          kill;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] show_ptr;
  logic [AW:0]   count;
  logic [AW+1:0] committed;
  logic          has_room;
  logic          fifo_nonempty;
  logic          push;
  logic          pop;

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  // A slot is committed once its request has gone out, so the in-flight
  // word is counted as occupying the FIFO; this is what makes overflow
  // impossible without any back-pressure on the memory side.
  assign committed     = {1'b0, count} + (AW+2)'(inflight);
  assign has_room      = committed < (AW+2)'(DEPTH);
  assign fifo_nonempty = (count != '0);

  assign imem_req_o  = rst_i & ~redirect_i & has_room;
  assign imem_addr_o = rst_i ? fetch_pc : RESET_PC;

  // A response landing in the redirect cycle belongs to the old path and is
  // dropped along with the flush; kill covers the cycle after the redirect.
  assign push = inflight & ~kill & ~redirect_i;
  assign pop  = fifo_nonempty & ready_i;

  // When empty, show the most recently consumed slot so the data outputs
  // keep their last values instead of exposing a stale older entry.
  assign show_ptr = fifo_nonempty ? rd_ptr : rd_ptr - AW'(1);

  assign valid_o    = rst_i & fifo_nonempty;
  assign instr_o    = rst_i ? instr_mem[show_ptr] : 32'h0;
  assign pc_o       = rst_i ? pc_mem[show_ptr] : 32'h0;
  assign pc_plus4_o = pc_o + 32'd4;

  // Control state: fetch PC, in-flight tracking and FIFO pointers/count.
  // Redirect takes priority over both push and pop in its cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      inflight    <= 1'b0;
      kill        <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      inflight <= imem_req_o;
      kill     <= redirect_i & inflight;
      if (imem_req_o) begin
        inflight_pc <= fetch_pc;
      end
      if (redirect_i) begin
        fetch_pc <= target_i & 32'hFFFF_FFFC;
        count    <= '0;
        rd_ptr   <= wr_ptr;
      end else begin
        if (imem_req_o) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (push && !pop) begin
          count <= count + (AW+1)'(1);
        end else if (pop && !push) begin
          count <= count - (AW+1)'(1);
        end
      end
    end
  end

  // Entry storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk_i) begin
    if (rst_i && push) begin
      pc_mem[wr_ptr]    <= inflight_pc;
      instr_mem[wr_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue.
//
// A behavioural memory returns an address-derived word one cycle after each
// request and random junk otherwise. A queue-based reference model tracks
// which PCs should be waiting for decode and what the next fetch address is.
// Directed steps cover streaming, back-pressure, redirects, PC wrap and
// mid-stream reset, followed by a randomized run.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] target_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_fpc  = RESET_PC;
  logic        m_pend = 1'b0;
  logic [31:0] m_ppc  = 32'h0;
  logic [31:0] mq[$];
  logic        exp_req;
  logic        exp_valid;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .redirect_i  (redirect_i),
    .target_i    (target_i),
    .imem_req_o  (imem_req_o),
    .imem_addr_o (imem_addr_o),
    .imem_rdata_i(imem_rdata_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .pc_plus4_o  (pc_plus4_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // One-cycle latency memory; unrequested cycles return noise so a word
  // wrongly captured would show up as a data error.
  always @(posedge clk_i) begin
    imem_rdata_i <= imem_req_o ? memWord(imem_addr_o) : $urandom;
  end

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs for the current cycle, from the model and the inputs.
  task automatic checkOutput();
    exp_req   = rst_i && !redirect_i && ((mq.size() + int'(m_pend)) < DEPTH);
    exp_valid = rst_i && (mq.size() > 0);
    checkValue("imem_req", 32'(imem_req_o), 32'(exp_req));
    checkValue("imem_addr", imem_addr_o, rst_i ? m_fpc : RESET_PC);
    checkValue("valid", 32'(valid_o), 32'(exp_valid));
    if (!rst_i) begin
      checkValue("instr_rst", instr_o, 32'h0);
      checkValue("pc_rst", pc_o, 32'h0);
      checkValue("pc_plus4_rst", pc_plus4_o, 32'h4);
    end else if (exp_valid) begin
      checkValue("pc", pc_o, mq[0]);
      checkValue("instr", instr_o, memWord(mq[0]));
      checkValue("pc_plus4", pc_plus4_o, mq[0] + 32'd4);
    end
  endtask

  // Advance the model across the clock edge just taken.
  task automatic updateModel();
    if (!rst_i) begin
      m_fpc  = RESET_PC;
      m_pend = 1'b0;
      mq.delete();
    end else if (redirect_i) begin
      mq.delete();
      m_fpc  = target_i & 32'hFFFF_FFFC;
      m_pend = 1'b0;
    end else begin
      if (exp_valid && ready_i) void'(mq.pop_front());
      if (m_pend) mq.push_back(m_ppc);
      m_pend = exp_req;
      if (exp_req) begin
        m_ppc = m_fpc;
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rd, input logic [31:0] tgt, input logic rdy);
    @(negedge clk_i);
    rst_i      = r;
    redirect_i = rd;
    target_i   = tgt;
    ready_i    = rdy;
    #1;
    checkOutput();
    @(posedge clk_i);
    updateModel();
  endtask

  initial begin
    logic r, rd, rdy;
    logic [31:0] tgt;

    $display("[TB] reset");
    repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

    $display("[TB] streaming with ready held high");
    repeat (10) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] back-pressure from reset, then drain");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] redirect with three entries and one in flight");
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0103, 1'b0);
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] redirect coinciding with a pop");
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] fetch PC wrap");
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] back-to-back redirects");
    applyStimulus(1'b1, 1'b1, 32'h0000_0300, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h0000_0406, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] reset with a full FIFO");
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) != 0);
      rd  = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      applyStimulus(r, rd, tgt, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
